// File: rtl/loopback_regs_pkg.sv
// -----------------------------------------------------------------------------
// loopback_regs_pkg
// Shared definitions for the loopback register block: register address map,
// fixed read values and CTRL bit positions.
// Configuration macro: LOOPBACK_REGS_ERR_CNT_EN adds ERR_CNT at 0x5.
// -----------------------------------------------------------------------------
package loopback_regs_pkg;

    typedef enum logic [3:0] {
        RegId       = 4'h0,
        RegScratch  = 4'h1,
        RegCtrl     = 4'h2,
        RegCycleCnt = 4'h3,
        RegWrCnt    = 4'h4,
        RegErrCnt   = 4'h5
    } reg_addr_e;

    localparam logic [31:0] IdValue  = 32'h4C50_0001;
    localparam logic [31:0] DeadBeef = 32'hDEAD_BEEF;

    localparam int unsigned CtrlEnableBit = 0;
    localparam int unsigned CtrlClearBit  = 1;

    // True for offsets that back a real register in this build.
    function automatic logic is_mapped(input logic [3:0] addr);
        logic mapped;
        mapped = (addr <= RegWrCnt);
`ifdef LOOPBACK_REGS_ERR_CNT_EN
        mapped = mapped | (addr == RegErrCnt);
`endif
        return mapped;
    endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// -----------------------------------------------------------------------------
// avalon_mm_if
// Minimal Avalon-MM interface without waitrequest; pipelined reads are
// answered through readdatavalid.
//   slave modport : address, read, write, writedata in; readdata,
//                   readdatavalid out
//   master modport: the mirror image
// -----------------------------------------------------------------------------
interface avalon_mm_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid
    );

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid
    );
endinterface

// File: rtl/loopback_regs_rdpipe.sv
// -----------------------------------------------------------------------------
// loopback_regs_rdpipe
// Fixed-latency read response pipe: valid + data shift register of DEPTH
// stages. Data is zeroed in stages that carry no valid, so the output data is
// 0 whenever the output valid is low.
//   clk       : clock, rising edge
//   clr       : synchronous flush of every stage
//   in_valid  : read sampled this cycle
//   in_data   : read data captured this cycle
//   out_valid : response strobe, DEPTH cycles after in_valid
//   out_data  : response data
// -----------------------------------------------------------------------------
module loopback_regs_rdpipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_valid ? in_data : '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/loopback_regs.sv
// -----------------------------------------------------------------------------
// loopback_regs
// Avalon-MM control/status register block for the loopback datapath.
// Zero-wait-state accesses, reads answered READ_LATENCY cycles later.
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   avs         : avalon_mm_if slave (word address, only address[3:0] decoded)
//   ctrl_enable : CTRL[0], enable to the loopback datapath
// Map: 0x0 ID, 0x1 SCRATCH, 0x2 CTRL, 0x3 CYCLE_CNT, 0x4 WR_CNT,
//      0x5 ERR_CNT (only with LOOPBACK_REGS_ERR_CNT_EN defined).
// Only DATA_WIDTH = 32 and READ_LATENCY in 1..4 are supported.
// -----------------------------------------------------------------------------
module loopback_regs
    import loopback_regs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    avalon_mm_if.slave avs,
    output logic       ctrl_enable
);

    logic [3:0]            reg_addr;
    logic                  rd_en;
    logic                  wr_en;
    logic                  addr_mapped;
    logic                  clear;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [31:0] scratch_q;
    logic        ctrl_en_q;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Upper address bits alias onto the 16-word map.
    logic unused_addr;
    assign unused_addr = ^avs.address[ADDR_WIDTH-1:4];

    assign reg_addr    = avs.address[3:0];
    // Accesses presented while in reset are dropped.
    assign rd_en       = avs.read & ~rst;
    assign wr_en       = avs.write & ~rst;
    assign addr_mapped = is_mapped(reg_addr);
    assign clear       = wr_en && (reg_addr == RegCtrl) && avs.writedata[CtrlClearBit];

`ifdef LOOPBACK_REGS_ERR_CNT_EN
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [1:0]  err_inc;
    logic [32:0] err_sum;

    // A read and a write to unmapped space in one cycle count as two errors.
    always_comb begin
        err_inc   = {1'b0, rd_en & ~addr_mapped} + {1'b0, wr_en & ~addr_mapped};
        err_sum   = {1'b0, err_cnt_q} + {31'd0, err_inc};
        err_cnt_d = err_sum[32] ? '1 : err_sum[31:0];
        if (clear) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

    // Read mux samples the pre-write register values of this cycle.
    always_comb begin
        rd_data = DeadBeef;
        case (reg_addr)
            RegId:       rd_data = IdValue;
            RegScratch:  rd_data = scratch_q;
            RegCtrl:     rd_data = {31'd0, ctrl_en_q};
            RegCycleCnt: rd_data = cycle_cnt_q;
            RegWrCnt:    rd_data = wr_cnt_q;
`ifdef LOOPBACK_REGS_ERR_CNT_EN
            RegErrCnt:   rd_data = err_cnt_q;
`endif
            default:     rd_data = DeadBeef;
        endcase
    end

    // Clear wins over any increment in the same cycle; the clearing write is
    // therefore never counted.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (clear) begin
            cycle_cnt_d = '0;
            wr_cnt_d    = '0;
        end else begin
            if (ctrl_en_q) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
            if (wr_en && addr_mapped && (wr_cnt_q != '1)) begin
                wr_cnt_d = wr_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch_q   <= '0;
            ctrl_en_q   <= 1'b0;
            cycle_cnt_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            if (wr_en && (reg_addr == RegScratch)) begin
                scratch_q <= avs.writedata;
            end
            if (wr_en && (reg_addr == RegCtrl)) begin
                ctrl_en_q <= avs.writedata[CtrlEnableBit];
            end
            cycle_cnt_q <= cycle_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign ctrl_enable = ctrl_en_q;

    loopback_regs_rdpipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (DATA_WIDTH)
    ) u_rdpipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (rd_en),
        .in_data   (rd_data),
        .out_valid (avs.readdatavalid),
        .out_data  (avs.readdata)
    );

endmodule

// File: tb/tb_loopback_regs.sv
// -----------------------------------------------------------------------------
// tb_loopback_regs
// Directed self-checking bench for loopback_regs. Inputs change 1 time unit
// after the rising edge; responses are collected on the falling edge together
// with the cycle number, and each scenario task compares them with its own
// hand-computed list.
// -----------------------------------------------------------------------------
module tb_loopback_regs;

    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic rst;
    logic ctrl_enable;

    avalon_mm_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) avs ();

    loopback_regs #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .avs         (avs),
        .ctrl_enable (ctrl_enable)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] rsp_data [$];
    int unsigned rsp_cyc [$];
    int unsigned exp_cyc [$];
    int unsigned idle_nonzero = 0;
    int total = 0;
    int bad = 0;

    always @(negedge clk) begin
        if (avs.readdatavalid === 1'b1) begin
            rsp_data.push_back(avs.readdata);
            rsp_cyc.push_back(cyc);
        end else if (avs.readdata !== 32'd0) begin
            idle_nonzero++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle of bus activity, then advance to the next cycle.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd);
        avs.read      = rd;
        avs.write     = wr;
        avs.address   = addr;
        avs.writedata = wd;
        if (rd) exp_cyc.push_back(cyc + LAT);
        tick();
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (LAT + 2) tick();
    endtask

    task automatic test_reset();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        total++;
        if (ctrl_enable !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl_enable: got %b, required 0", ctrl_enable);
        end
        total++;
        if (avs.readdatavalid !== 1'b0) begin
            bad++; $display("FAIL reset_rdvalid: got %b, required 0", avs.readdatavalid);
        end
        total++;
        if (avs.readdata !== 32'd0) begin
            bad++; $display("FAIL reset_rddata: got %h, required 0", avs.readdata);
        end
        drive(1'b1, 1'b0, 32'h0, 32'd0);
        settle();
        want = '{32'h4C50_0001};
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL id_read[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL id_read[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL id_read_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_scratch();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        drive(1'b1, 1'b1, 32'h1, 32'hA5A5_5A5A);  // write + same-cycle read
        drive(1'b1, 1'b0, 32'h1, 32'd0);
        drive(1'b1, 1'b0, 32'h4, 32'd0);
        settle();
        want = '{32'h0, 32'hA5A5_5A5A, 32'h1};
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL scratch[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL scratch[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL scratch_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        drive(1'b1, 1'b0, 32'h0, 32'd0);
        drive(1'b1, 1'b0, 32'h1, 32'd0);
        drive(1'b1, 1'b0, 32'h7, 32'd0);
        drive(1'b1, 1'b0, 32'h4, 32'd0);
        settle();
        want = '{32'h4C50_0001, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 32'h1};
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL b2b[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL b2b[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL b2b_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_ctrl_clear();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        drive(1'b0, 1'b1, 32'h2, 32'h1);          // enable on
        repeat (4) drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'h3, 32'd0);          // 4 enabled edges so far
        repeat (5) drive(1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 32'h2, 32'h3);          // enable + clear
        drive(1'b1, 1'b0, 32'h4, 32'd0);
        drive(1'b1, 1'b0, 32'h3, 32'd0);
        drive(1'b1, 1'b0, 32'h2, 32'd0);
        settle();
        total++;
        if (ctrl_enable !== 1'b1) begin
            bad++; $display("FAIL clear_ctrl_enable: got %b, required 1", ctrl_enable);
        end
        want = '{32'd4, 32'd0, 32'd1, 32'd1};
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL ctrl_clear[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL ctrl_clear[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL ctrl_clear_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_ctrl_bits_alias();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        drive(1'b0, 1'b1, 32'h2, 32'hFFFF_FFFC);  // enable off, no clear
        total++;
        if (ctrl_enable !== 1'b0) begin
            bad++; $display("FAIL ctrl_off: got %b, required 0", ctrl_enable);
        end
        drive(1'b0, 1'b1, 32'h2, 32'hFFFF_FFFD);  // enable on, no clear
        total++;
        if (ctrl_enable !== 1'b1) begin
            bad++; $display("FAIL ctrl_on: got %b, required 1", ctrl_enable);
        end
        drive(1'b1, 1'b0, 32'h2, 32'd0);
        drive(1'b1, 1'b0, 32'h10, 32'd0);         // aliases ID
        drive(1'b1, 1'b0, 32'h12, 32'd0);         // aliases CTRL
        drive(1'b0, 1'b1, 32'h6, 32'h1234_5678);  // unmapped, dropped
        drive(1'b1, 1'b0, 32'h6, 32'd0);
        drive(1'b1, 1'b0, 32'h4, 32'd0);
        settle();
        want = '{32'h1, 32'h4C50_0001, 32'h1, 32'hDEAD_BEEF, 32'h2};
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL ctrl_alias[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL ctrl_alias[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL ctrl_alias_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_err_cnt();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        drive(1'b0, 1'b1, 32'h2, 32'h3);          // zero counters, keep enable
        drive(1'b0, 1'b1, 32'h9, 32'hAAAA_0000);
        drive(1'b0, 1'b1, 32'h9, 32'hBBBB_0000);
        drive(1'b1, 1'b0, 32'h5, 32'd0);
        settle();
`ifdef LOOPBACK_REGS_ERR_CNT_EN
        want = '{32'd2};
`else
        want = '{32'hDEAD_BEEF};
`endif
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL err_cnt[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL err_cnt[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL err_cnt_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_reset_flush();
        logic [31:0] want [$];
        logic [31:0] d;
        int unsigned c, e;
        drive(1'b0, 1'b1, 32'h1, 32'h1111_2222);
        drive(1'b0, 1'b1, 32'h2, 32'h1);
        drive(1'b1, 1'b0, 32'h0, 32'd0);          // in flight when reset hits
        rst = 1'b1;
        drive(1'b1, 1'b1, 32'h1, 32'hFFFF_0000);  // ignored while in reset
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        settle();
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL flush: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
        total++;
        if (ctrl_enable !== 1'b0) begin
            bad++; $display("FAIL flush_ctrl_enable: got %b, required 0", ctrl_enable);
        end
        drive(1'b1, 1'b0, 32'h1, 32'd0);
        drive(1'b1, 1'b0, 32'h4, 32'd0);
        drive(1'b1, 1'b0, 32'h3, 32'd0);
        settle();
        want = '{32'h0, 32'h0, 32'h0};
        for (int i = 0; i < want.size(); i++) begin
            total++;
            if (rsp_data.size() == 0) begin
                bad++; $display("FAIL post_reset[%0d]: no response, required %h", i, want[i]);
            end else begin
                d = rsp_data.pop_front(); c = rsp_cyc.pop_front(); e = exp_cyc.pop_front();
                if (d !== want[i] || c != e) begin
                    bad++;
                    $display("FAIL post_reset[%0d]: data %h cycle %0d, required data %h cycle %0d",
                             i, d, c, want[i], e);
                end
            end
        end
        total++;
        if (rsp_data.size() != 0) begin
            bad++; $display("FAIL post_reset_extra: got %0d responses, required 0", rsp_data.size());
        end
        rsp_data.delete(); rsp_cyc.delete(); exp_cyc.delete();
    endtask

    task automatic test_idle_zero();
        total++;
        if (idle_nonzero != 0) begin
            bad++; $display("FAIL idle_readdata: %0d nonzero idle cycles, required 0", idle_nonzero);
        end
    endtask

    initial begin
        rst           = 1'b1;
        avs.read      = 1'b0;
        avs.write     = 1'b0;
        avs.address   = 32'd0;
        avs.writedata = 32'd0;
        test_reset();
        test_scratch();
        test_back_to_back();
        test_ctrl_clear();
        test_ctrl_bits_alias();
        test_err_cnt();
        test_reset_flush();
        test_idle_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loopback_regs.md
LOOPBACK_REGS -- requirements
Module: loopback_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, Avalon-MM data width; only 32 supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, Avalon-MM word-address width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from read sample to readdatavalid; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port avs.address, input, ADDR_WIDTH, word address (slave modport of avalon_mm_if).
REQ-007 SHALL have port avs.read, input, 1, read request, one access per asserted cycle.
REQ-008 SHALL have port avs.write, input, 1, write request, one access per asserted cycle.
REQ-009 SHALL have port avs.writedata, input, DATA_WIDTH, write data.
REQ-010 SHALL have port avs.readdata, output, DATA_WIDTH, read data, valid only with readdatavalid.
REQ-011 SHALL have port avs.readdatavalid, output, 1, read response strobe.
REQ-012 SHALL have port ctrl_enable, output, 1, CTRL[0] to the loopback datapath.

Function
REQ-013 SHALL decode address[3:0] only; upper bits ignored (aliasing accepted).
REQ-014 SHALL map: 0x0 ID ro = 32'h4C50_0001; 0x1 SCRATCH rw; 0x2 CTRL rw; 0x3 CYCLE_CNT ro; 0x4 WR_CNT ro; all others unmapped.
REQ-015 SHALL return 32'hDEAD_BEEF on unmapped reads and ignore unmapped writes.
REQ-016 SHALL accept every read/write with no wait states (no waitrequest).
REQ-017 SHALL assert readdatavalid exactly READ_LATENCY cycles after the cycle read was sampled high, one pulse per read.
REQ-018 SHALL support back-to-back reads every cycle, responses in order, no bubbles.
REQ-019 SHALL capture read data in the sample cycle; a write to the same register in that cycle is not visible to that read.
REQ-020 SHALL let write take effect on the next edge; read+write in one cycle both execute.
REQ-021 SHALL drive readdata to 0 on cycles where readdatavalid is 0.
REQ-022 CTRL: bit0 enable (rw), bit1 clear (write-1 self-clearing, reads 0), bits[31:2] read 0.
REQ-023 CYCLE_CNT SHALL increment by 1 each cycle enable=1, wrapping 0xFFFF_FFFF -> 0.
REQ-024 WR_CNT SHALL increment on each accepted write to any mapped address, saturating at 0xFFFF_FFFF.
REQ-025 CTRL clear SHALL zero CYCLE_CNT and WR_CNT on the edge after the write, overriding any same-cycle increment; the clearing write itself is not counted.

Reset
REQ-026 SHALL on rst: SCRATCH, CTRL, CYCLE_CNT, WR_CNT = 0; ctrl_enable = 0; readdata = 0; readdatavalid = 0.
REQ-027 SHALL flush the read pipeline on rst; reads in flight produce no response; accesses while rst=1 are ignored.

Configuration
REQ-028 With LOOPBACK_REGS_ERR_CNT_EN defined: register 0x5 ERR_CNT ro counts reads/writes to unmapped addresses, saturating, cleared by CTRL clear and reset.
REQ-029 Without LOOPBACK_REGS_ERR_CNT_EN: 0x5 is unmapped (returns 32'hDEAD_BEEF), no counter logic.

Structure
REQ-030 SHALL place register address enum, ID constant, DEAD_BEEF constant and CTRL bit indices in package loopback_regs_pkg.
REQ-031 SHALL implement the read response delay as sub-module loopback_regs_rdpipe (valid+data shift register, depth READ_LATENCY, sync clear).

Verification
REQ-032 Reset, then read 0x0 -> readdatavalid exactly 2 cycles later, readdata 32'h4C50_0001.
REQ-033 Write SCRATCH 32'hA5A5_5A5A with same-cycle read 0x1 -> read returns 0; next read returns 32'hA5A5_5A5A; WR_CNT reads 1.
REQ-034 Reads 0x0,0x1,0x7,0x4 on 4 consecutive cycles -> 4 consecutive valid pulses, data ID, SCRATCH, DEAD_BEEF, WR_CNT in order.
REQ-035 Write CTRL 1, idle 10 cycles, write CTRL 3 -> CYCLE_CNT reads small value restarted from 0, WR_CNT reads 0, CTRL reads 1.
REQ-036 Issue read, assert rst in next cycle -> no readdatavalid; post-reset SCRATCH=0, ctrl_enable=0.
REQ-037 With LOOPBACK_REGS_ERR_CNT_EN: write 0x9 twice, read 0x5 -> 2; without macro read 0x5 -> 32'hDEAD_BEEF.
